// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the MIPS register file: post-reset zero sweep, then
// writeback-over-MDU fixed priority with a starvation-driven pipeline stall request.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter bit          CLEAR_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic        init_done,
  output logic        err_wb_drop
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [3:0] STALL_AT = 4'(STARVE_LIMIT - 1);

  state_t      state_q, state_d;
  logic [4:0]  clr_addr_q, clr_addr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        pipe_stall_q, pipe_stall_d;
  logic        init_done_q, init_done_d;
  logic        err_wb_drop_q, err_wb_drop_d;

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    starve_cnt_d  = starve_cnt_q;
    pipe_stall_d  = pipe_stall_q;
    init_done_d   = init_done_q;
    err_wb_drop_d = err_wb_drop_q;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    mdu_ready     = 1'b0;

    if (reset) begin
      state_d       = CLEAR_EN ? S_CLEAR : S_RUN;
      clr_addr_d    = 5'd1;
      starve_cnt_d  = '0;
      pipe_stall_d  = 1'b0;
      init_done_d   = ~CLEAR_EN;
      err_wb_drop_d = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          rf_we      = 1'b1;
          rf_waddr   = clr_addr_q;
          clr_addr_d = clr_addr_q + 5'd1;
          if (wb_en) err_wb_drop_d = 1'b1;
          if (clr_addr_q == 5'd31) begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
          end
        end
        S_RUN: begin
          // A writeback to r0 is discarded and hands its slot to the MDU.
          if (wb_en && wb_addr != '0) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
          end else begin
            mdu_ready = 1'b1;
            if (mdu_valid) begin
              rf_we    = (mdu_addr != '0);
              rf_waddr = mdu_addr;
              rf_wdata = mdu_data;
            end
          end

          if (mdu_valid && !mdu_ready) begin
            if (starve_cnt_q != 4'hF) starve_cnt_d = starve_cnt_q + 4'd1;
            if (starve_cnt_q == STALL_AT) pipe_stall_d = 1'b1;
          end else begin
            starve_cnt_d = '0;
          end
          if (mdu_valid && mdu_ready) pipe_stall_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state_q       <= state_d;
    clr_addr_q    <= clr_addr_d;
    starve_cnt_q  <= starve_cnt_d;
    pipe_stall_q  <= pipe_stall_d;
    init_done_q   <= init_done_d;
    err_wb_drop_q <= err_wb_drop_d;
  end

  assign pipe_stall  = pipe_stall_q;
  assign init_done   = init_done_q;
  assign err_wb_drop = err_wb_drop_q;

endmodule
